// File: rtl/video_stream_pkg.sv
`default_nettype none
// ============================================================================
// Module      : video_stream_pkg
// Description : Shared definitions for the sparse pixel-stream blocks:
//               generator state encoding, pattern codes and coordinate width.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package video_stream_pkg;

    // Width of x/y coordinates, frame counter and pattern arithmetic.
    localparam int COORD_W = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        HBLANK = 2'd2,
        VBLANK = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        PAT_HRAMP = 2'd0,
        PAT_VRAMP = 2'd1,
        PAT_CHECK = 2'd2,
        PAT_DIAG  = 2'd3
    } pattern_t;

endpackage
`default_nettype wire

// File: rtl/video_pattern_tx.sv
`default_nettype none
// ============================================================================
// Module      : video_pattern_tx
// Description : Synthetic frame generator for the sparse pixel-stream
//               protocol. Emits one pixel every SPARSE_OUTPUT+1 cycles with
//               de/hs/vs strobes, H_BLANK idle cycles between lines and
//               V_BLANK idle cycles after the last line of a frame.
// Ports       : clk          - sole clock
//               rst_n        - synchronous active-low reset
//               enable       - start/continue frame generation (IDLE only)
//               line_size    - pixels per line minus 1 (latched at frame start)
//               frame_lines  - lines per frame minus 1 (latched at frame start)
//               pattern_sel  - 0 h-ramp, 1 v-ramp, 2 checkerboard, 3 diagonal
//               do_o         - pixel data, valid with de_o, held otherwise
//               de_o         - pixel valid
//               hs_o         - first pixel of a line
//               vs_o         - first pixel of a frame
//               frame_done   - one-cycle pulse at the end of vertical blank
//               busy         - high in every state except IDLE
// Revision    : 1.0 - initial release
// ============================================================================
module video_pattern_tx
    import video_stream_pkg::*;
#(
    parameter int PIXEL_WIDTH   = 12,
    parameter int SPARSE_OUTPUT = 2,
    parameter int H_BLANK       = 16,
    parameter int V_BLANK       = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable,
    input  logic [15:0]            line_size,
    input  logic [15:0]            frame_lines,
    input  logic [1:0]             pattern_sel,
    output logic [PIXEL_WIDTH-1:0] do_o,
    output logic                   de_o,
    output logic                   hs_o,
    output logic                   vs_o,
    output logic                   frame_done,
    output logic                   busy
);

    localparam int SP_W      = (SPARSE_OUTPUT > 0) ? $clog2(SPARSE_OUTPUT + 1) : 1;
    localparam int BLANK_MAX = (H_BLANK > V_BLANK) ? H_BLANK : V_BLANK;
    localparam int BL_W      = (BLANK_MAX > 1) ? $clog2(BLANK_MAX) : 1;

    localparam logic [SP_W-1:0] SP_LAST = SP_W'(SPARSE_OUTPUT);
    // Blank counters run 0..N-1; the last count triggers the state exit.
    localparam logic [BL_W-1:0] HB_LAST = BL_W'((H_BLANK > 0) ? H_BLANK - 1 : 0);
    localparam logic [BL_W-1:0] VB_LAST = BL_W'((V_BLANK > 0) ? V_BLANK - 1 : 0);

    state_t               state,      state_d;
    logic [COORD_W-1:0]   x,          x_d;
    logic [COORD_W-1:0]   y,          y_d;
    logic [SP_W-1:0]      cnt_sparse, cnt_sparse_d;
    logic [BL_W-1:0]      blank_cnt,  blank_cnt_d;
    logic [COORD_W-1:0]   frame_cnt,  frame_cnt_d;
    logic [15:0]          ls_q,       ls_d;
    logic [15:0]          fl_q,       fl_d;
    pattern_t             pat_q,      pat_d;

    logic [PIXEL_WIDTH-1:0] do_d;
    logic                   de_d, hs_d, vs_d, done_d, busy_d;

    // Pattern mux: arithmetic in coordinate width, truncated to pixel width.
    function automatic logic [PIXEL_WIDTH-1:0] pattern_pixel(
        input pattern_t           sel,
        input logic [COORD_W-1:0] px,
        input logic [COORD_W-1:0] py,
        input logic [COORD_W-1:0] fc
    );
        logic [COORD_W-1:0] v;
        v = '0;
        case (sel)
            PAT_HRAMP: v = px;
            PAT_VRAMP: v = py;
            PAT_DIAG:  v = px + py + fc;
            default:   v = '0;
        endcase
        if (sel == PAT_CHECK) begin
            return {PIXEL_WIDTH{px[3] ^ py[3]}};
        end
        return PIXEL_WIDTH'(v);
    endfunction

    always_comb begin
        state_d      = state;
        x_d          = x;
        y_d          = y;
        cnt_sparse_d = cnt_sparse;
        blank_cnt_d  = blank_cnt;
        frame_cnt_d  = frame_cnt;
        ls_d         = ls_q;
        fl_d         = fl_q;
        pat_d        = pat_q;
        do_d         = do_o;
        de_d         = 1'b0;
        hs_d         = 1'b0;
        vs_d         = 1'b0;
        done_d       = 1'b0;

        case (state)
            IDLE: begin
                if (enable) begin
                    ls_d         = line_size;
                    fl_d         = frame_lines;
                    pat_d        = pattern_t'(pattern_sel);
                    x_d          = '0;
                    y_d          = '0;
                    cnt_sparse_d = '0;
                    state_d      = ACTIVE;
                end
            end

            ACTIVE: begin
                if (cnt_sparse == SP_LAST) begin
                    cnt_sparse_d = '0;
                    de_d         = 1'b1;
                    hs_d         = (x == '0);
                    vs_d         = (x == '0) && (y == '0);
                    do_d         = pattern_pixel(pat_q, x, y, frame_cnt);
                    x_d          = x + 16'd1;
                    if (x == ls_q) begin
                        blank_cnt_d = '0;
                        if (y == fl_q) begin
                            if (V_BLANK == 0) begin
                                done_d      = 1'b1;
                                frame_cnt_d = frame_cnt + 16'd1;
                                state_d     = IDLE;
                            end else begin
                                state_d = VBLANK;
                            end
                        end else if (H_BLANK == 0) begin
                            // No horizontal blank: start the next line at once.
                            x_d = '0;
                            y_d = y + 16'd1;
                        end else begin
                            state_d = HBLANK;
                        end
                    end
                end else begin
                    cnt_sparse_d = cnt_sparse + 1'b1;
                end
            end

            HBLANK: begin
                if (blank_cnt == HB_LAST) begin
                    x_d          = '0;
                    y_d          = y + 16'd1;
                    cnt_sparse_d = '0;
                    state_d      = ACTIVE;
                end else begin
                    blank_cnt_d = blank_cnt + 1'b1;
                end
            end

            VBLANK: begin
                if (blank_cnt == VB_LAST) begin
                    done_d      = 1'b1;
                    frame_cnt_d = frame_cnt + 16'd1;
                    state_d     = IDLE;
                end else begin
                    blank_cnt_d = blank_cnt + 1'b1;
                end
            end

            default: state_d = IDLE;
        endcase

        // Registered from the next state so busy tracks the state exactly.
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            x          <= '0;
            y          <= '0;
            cnt_sparse <= '0;
            blank_cnt  <= '0;
            frame_cnt  <= '0;
            ls_q       <= '0;
            fl_q       <= '0;
            pat_q      <= PAT_HRAMP;
            do_o       <= '0;
            de_o       <= 1'b0;
            hs_o       <= 1'b0;
            vs_o       <= 1'b0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_d;
            x          <= x_d;
            y          <= y_d;
            cnt_sparse <= cnt_sparse_d;
            blank_cnt  <= blank_cnt_d;
            frame_cnt  <= frame_cnt_d;
            ls_q       <= ls_d;
            fl_q       <= fl_d;
            pat_q      <= pat_d;
            do_o       <= do_d;
            de_o       <= de_d;
            hs_o       <= hs_d;
            vs_o       <= vs_d;
            frame_done <= done_d;
            busy       <= busy_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_video_pattern_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_video_pattern_tx
// Description : Scoreboard bench for video_pattern_tx. Stimulus pushes the
//               expected pixels (edge number, data, hs, vs) and frame_done
//               edges into queues; a negedge monitor pops and compares.
//               Edges are numbered by edge_num; a value observed at a negedge
//               belongs to the edge edge_num that produced it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_video_pattern_tx;
    import video_stream_pkg::*;

    localparam int PW  = 12;
    localparam int SP  = 2;
    localparam int HB  = 16;
    localparam int VB  = 64;
    localparam int PER = SP + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic [15:0]   line_size = '0;
    logic [15:0]   frame_lines = '0;
    logic [1:0]    pattern_sel = '0;
    logic [PW-1:0] do_o;
    logic          de_o, hs_o, vs_o, frame_done, busy;

    video_pattern_tx #(
        .PIXEL_WIDTH  (PW),
        .SPARSE_OUTPUT(SP),
        .H_BLANK      (HB),
        .V_BLANK      (VB)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .line_size  (line_size),
        .frame_lines(frame_lines),
        .pattern_sel(pattern_sel),
        .do_o       (do_o),
        .de_o       (de_o),
        .hs_o       (hs_o),
        .vs_o       (vs_o),
        .frame_done (frame_done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int edge_num = 0;
    always @(posedge clk) edge_num <= edge_num + 1;

    typedef struct {
        int          t;
        int          x;
        int          y;
        logic [PW-1:0] d;
        logic        hs;
        logic        vs;
    } exp_t;

    exp_t exp_q[$];
    int   done_q[$];
    int   total = 0;
    int   bad   = 0;
    int   phase = 0;
    int   fc    = 0;
    logic [PW-1:0] cap_a = '0, cap_b = '0, cap_c = '0;

    task automatic check(input string name, input longint act, input longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h (edge %0d)", name, act, req, edge_num);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s: event not expected (edge %0d)", name, edge_num);
    endtask

    function automatic logic [PW-1:0] model(input int pat, input int x, input int y, input int f);
        logic [15:0] s;
        case (pat)
            0:       s = 16'(x);
            1:       s = 16'(y);
            2:       s = (((x >> 3) & 1) != ((y >> 3) & 1)) ? 16'hFFFF : 16'h0000;
            default: s = 16'(x + y + f);
        endcase
        return s[PW-1:0];
    endfunction

    // Edge at which frame_done is produced: the pulse is visible in the
    // cycle after this edge, i.e. the frame-length formula minus one.
    function automatic int done_edge(input int t0, input int ls, input int fl);
        return t0 + (fl + 1) * (ls + 1) * PER + fl * HB + VB;
    endfunction

    // Push the expected pixels of a frame; max_pix < 0 means the full frame
    // including its frame_done, otherwise only the first max_pix pixels.
    task automatic push_frame(input int t0, input int ls, input int fl,
                              input int pat, input int f, input int max_pix);
        exp_t e;
        int   n;
        n = 0;
        for (int j = 0; j <= fl; j++) begin
            for (int i = 0; i <= ls; i++) begin
                if (max_pix < 0 || n < max_pix) begin
                    e.t  = t0 + PER * (i + 1) + j * ((ls + 1) * PER + HB);
                    e.x  = i;
                    e.y  = j;
                    e.d  = model(pat, i, j, f);
                    e.hs = (i == 0);
                    e.vs = (i == 0) && (j == 0);
                    exp_q.push_back(e);
                end
                n++;
            end
        end
        if (max_pix < 0) done_q.push_back(done_edge(t0, ls, fl));
    endtask

    task automatic wait_until(input int t);
        while (edge_num < t) @(negedge clk);
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a pixel or
    // frame_done, and flags strobes that appear without de_o.
    always @(negedge clk) begin
        exp_t e;
        if (de_o) begin
            if (exp_q.size() == 0) begin
                fail_now("unexpected_pixel");
            end else begin
                e = exp_q.pop_front();
                check($sformatf("pix_time(%0d,%0d)", e.x, e.y), edge_num, e.t);
                check($sformatf("pix_data(%0d,%0d)", e.x, e.y), do_o, e.d);
                check($sformatf("pix_hsvs(%0d,%0d)", e.x, e.y), {hs_o, vs_o}, {e.hs, e.vs});
                if (phase == 2 && e.x == 8 && e.y == 0) cap_a = do_o;
                if (phase == 2 && e.x == 0 && e.y == 8) cap_b = do_o;
                if (phase == 2 && e.x == 8 && e.y == 8) cap_c = do_o;
                if (phase == 3 && e.x == 4095) cap_a = do_o;
                if (phase == 3 && e.x == 4096) cap_b = do_o;
                if (phase == 3 && e.x == 4200) cap_c = do_o;
            end
        end else if (hs_o || vs_o) begin
            fail_now("strobe_without_de");
        end
        if (frame_done) begin
            if (done_q.size() == 0) fail_now("unexpected_frame_done");
            else check("frame_done_time", edge_num, done_q.pop_front());
        end
    end

    task automatic start_frame(input int ls, input int fl, input int pat, output int t0);
        line_size   = 16'(ls);
        frame_lines = 16'(fl);
        pattern_sel = 2'(pat);
        enable      = 1'b1;
        t0          = edge_num + 1;
    endtask

    initial begin
        int t0, t1, t2;
        int ta[8];
        exp_t e;
        ta = '{3, 6, 9, 12, 31, 34, 37, 40};

        // Reset, then 100 idle cycles with enable low.
        repeat (3) @(negedge clk);
        check("reset_outputs", {do_o, de_o, hs_o, vs_o, frame_done, busy}, 0);
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            repeat (10) @(negedge clk);
            check("idle_outputs", {do_o, de_o, hs_o, vs_o, frame_done, busy}, 0);
        end

        // Small frame, h-ramp, one-cycle enable pulse; hand-computed table.
        phase = 1;
        start_frame(3, 1, 0, t0);
        for (int k = 0; k < 8; k++) begin
            e.t  = t0 + ta[k];
            e.x  = k % 4;
            e.y  = k / 4;
            e.d  = PW'(k % 4);
            e.hs = (k % 4 == 0);
            e.vs = (k == 0);
            exp_q.push_back(e);
        end
        done_q.push_back(t0 + 104);
        fc++;
        @(negedge clk);
        enable = 1'b0;
        wait_until(t0 + 50);
        check("busy_mid_frame", busy, 1);
        wait_until(t0 + 110);
        check("busy_after_frame", busy, 0);
        check("drained_small", exp_q.size() + done_q.size(), 0);

        // Checkerboard 16x16.
        phase = 2;
        start_frame(15, 15, 2, t0);
        push_frame(t0, 15, 15, 2, fc, -1);
        fc++;
        @(negedge clk);
        enable = 1'b0;
        wait_until(done_edge(t0, 15, 15) + 5);
        check("check_8_0", cap_a, 12'hFFF);
        check("check_0_8", cap_b, 12'hFFF);
        check("check_8_8", cap_c, 12'h000);
        check("drained_check", exp_q.size() + done_q.size(), 0);

        // Long single line: ramp wraps at 4096.
        phase = 3;
        start_frame(4200, 0, 0, t0);
        push_frame(t0, 4200, 0, 0, fc, -1);
        fc++;
        @(negedge clk);
        enable = 1'b0;
        wait_until(done_edge(t0, 4200, 0) + 5);
        check("wrap_4095", cap_a, 12'hFFF);
        check("wrap_4096", cap_b, 12'h000);
        check("wrap_4200", cap_c, 12'h068);
        check("drained_wrap", exp_q.size() + done_q.size(), 0);

        // Enable held: three back-to-back frames, mid-frame input changes.
        phase = 4;
        start_frame(3, 1, 0, t0);
        t1 = done_edge(t0, 3, 1) + 1;
        t2 = done_edge(t1, 3, 1) + 1;
        push_frame(t0, 3, 1, 0, fc, -1);
        push_frame(t1, 3, 1, 3, fc + 1, -1);
        push_frame(t2, 3, 1, 3, fc + 2, -1);
        fc += 3;
        wait_until(t0 + 20);
        line_size = 16'd7;
        wait_until(t0 + 40);
        pattern_sel = 2'd3;
        wait_until(t0 + 60);
        line_size = 16'd3;
        wait_until(t2 + 40);
        enable = 1'b0;
        wait_until(done_edge(t2, 3, 1) + 100);
        check("busy_after_hold", busy, 0);
        check("drained_hold", exp_q.size() + done_q.size(), 0);

        // Reset while pixel 2 is on the output.
        phase = 5;
        start_frame(3, 1, 0, t0);
        push_frame(t0, 3, 1, 0, fc, 3);
        @(negedge clk);
        enable = 1'b0;
        wait_until(t0 + 9);
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_strobes", {de_o, hs_o, vs_o}, 0);
        check("rst_busy_data", {busy, do_o}, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        fc = 0;
        repeat (20) @(negedge clk);
        check("drained_reset", exp_q.size() + done_q.size(), 0);
        start_frame(3, 1, 3, t0);
        push_frame(t0, 3, 1, 3, fc, -1);
        @(negedge clk);
        enable = 1'b0;
        wait_until(done_edge(t0, 3, 1) + 10);
        check("busy_final", busy, 0);
        check("drained_final", exp_q.size() + done_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
